// File: rtl/edge_hysteresis_pkg.sv
// Shared types and helpers for the Canny hysteresis edge tracker.
package edge_hysteresis_pkg;

  typedef logic [1:0] strength_t;

  localparam strength_t STR_NONE   = 2'b00;
  localparam strength_t STR_WEAK   = 2'b01;
  localparam strength_t STR_STRONG = 2'b10;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } hyst_state_t;

  // 2'b11 is not a legal class upstream, so it is folded into strong
  function automatic logic is_strong(input strength_t s);
    return s[1];
  endfunction

  function automatic logic is_weak(input strength_t s);
    return (s == STR_WEAK);
  endfunction

endpackage

// File: rtl/strength_line_buffer.sv
// Fixed-depth shift line buffer of 2-bit strengths; contents are never cleared.
module strength_line_buffer
  import edge_hysteresis_pkg::*;
#(
  parameter int DEPTH = 640
) (
  input  logic       clk,
  input  logic       shift_en,
  input  logic [1:0] din,
  output logic [1:0] tap0,
  output logic [1:0] tap1,
  output logic [1:0] dout
);

  strength_t mem_r [DEPTH];

  // Shift chain: stage 0 takes the newest sample, last stage is the oldest
  always_ff @(posedge clk) begin
    if (shift_en) begin
      mem_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem_r[i] <= mem_r[i-1];
      end
    end
  end

  assign tap0 = mem_r[0];
  assign tap1 = mem_r[1];
  assign dout = mem_r[DEPTH-1];

endmodule

// File: rtl/edge_hysteresis.sv
// Streaming hysteresis: keeps strong pixels and weak pixels with a strong 8-neighbour.
module edge_hysteresis
  import edge_hysteresis_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] strength,
  input  logic       str_valid,
  output logic       edge_flag,
  output logic       edge_valid,
  output logic       frame_done,
  output logic       frame_err
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam int CNT_W = $clog2(IMG_WIDTH + 2);

  localparam logic [COL_W-1:0] COL_ZERO   = COL_W'(0);
  localparam logic [COL_W-1:0] COL_ONE    = COL_W'(1);
  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_ZERO   = ROW_W'(0);
  localparam logic [ROW_W-1:0] ROW_ONE    = ROW_W'(1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] FILL_FULL  = CNT_W'(IMG_WIDTH + 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(IMG_WIDTH);

  hyst_state_t      state_r, state_s;
  logic [COL_W-1:0] in_col_r, out_col_r;
  logic [ROW_W-1:0] in_row_r, out_row_r;
  logic [CNT_W-1:0] fill_r, flush_r;
  logic             shift_s, emit_s, err_set_s, in_last_s, out_last_s;
  strength_t        din_s;

  strength_t lb_lo_tap0_s, lb_lo_tap1_s, lb_lo_out_s;
  strength_t lb_hi_tap0_s, lb_hi_tap1_s, lb_hi_out_s;
  strength_t top_c_r, top_l_r;
  logic      up_ok_s, dn_ok_s, lf_ok_s, rt_ok_s, nb_strong_s, edge_s;

  logic edge_r, edge_valid_r, frame_done_r, frame_err_r;

  assign in_last_s  = (in_col_r == COL_LAST) && (in_row_r == ROW_LAST);
  assign out_last_s = (out_col_r == COL_LAST) && (out_row_r == ROW_LAST);

  // Next-state and shift/emit control
  always_comb begin
    state_s   = state_r;
    shift_s   = 1'b0;
    emit_s    = 1'b0;
    err_set_s = 1'b0;
    din_s     = STR_NONE;
    case (state_r)
      ST_RUN: begin
        if (str_valid) begin
          shift_s = 1'b1;
          din_s   = strength;
          emit_s  = (fill_r == FILL_FULL);
          state_s = in_last_s ? ST_FLUSH : ST_RUN;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_FLUSH: begin
        shift_s   = 1'b1;
        emit_s    = 1'b1;
        err_set_s = str_valid;
        state_s   = (flush_r == FLUSH_LAST) ? ST_RUN : ST_FLUSH;
      end
      default: begin
        state_s = ST_RUN;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_RUN;
    else        state_r <= state_s;
  end

  // Input position, fill level and flush progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_col_r <= COL_ZERO;
      in_row_r <= ROW_ZERO;
      fill_r   <= CNT_ZERO;
      flush_r  <= CNT_ZERO;
    end else begin
      if ((state_r == ST_RUN) && str_valid) begin
        if (in_col_r == COL_LAST) begin
          in_col_r <= COL_ZERO;
          in_row_r <= (in_row_r == ROW_LAST) ? ROW_ZERO : in_row_r + ROW_ONE;
        end else begin
          in_col_r <= in_col_r + COL_ONE;
        end
        if (in_last_s)               fill_r <= CNT_ZERO;
        else if (fill_r != FILL_FULL) fill_r <= fill_r + CNT_ONE;
      end
      if (state_r == ST_FLUSH) begin
        flush_r <= (flush_r == FLUSH_LAST) ? CNT_ZERO : flush_r + CNT_ONE;
      end
    end
  end

  // Output position tracks the pixel whose decision is being registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_col_r <= COL_ZERO;
      out_row_r <= ROW_ZERO;
    end else if (emit_s) begin
      if (out_col_r == COL_LAST) begin
        out_col_r <= COL_ZERO;
        out_row_r <= (out_row_r == ROW_LAST) ? ROW_ZERO : out_row_r + ROW_ONE;
      end else begin
        out_col_r <= out_col_r + COL_ONE;
      end
    end
  end

  strength_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb_lo (
    .clk      (clk),
    .shift_en (shift_s),
    .din      (din_s),
    .tap0     (lb_lo_tap0_s),
    .tap1     (lb_lo_tap1_s),
    .dout     (lb_lo_out_s)
  );

  strength_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb_hi (
    .clk      (clk),
    .shift_en (shift_s),
    .din      (lb_lo_out_s),
    .tap0     (lb_hi_tap0_s),
    .tap1     (lb_hi_tap1_s),
    .dout     (lb_hi_out_s)
  );

  // Top-row taps extend the delay line past the second line buffer
  always_ff @(posedge clk) begin
    if (shift_s) begin
      top_c_r <= lb_hi_out_s;
      top_l_r <= top_c_r;
    end
  end

  // Decision looks at the window as it will be after this shift, so the
  // registered result lands one cycle after the pixel that completes it
  always_comb begin
    up_ok_s     = (out_row_r != ROW_ZERO);
    dn_ok_s     = (out_row_r != ROW_LAST);
    lf_ok_s     = (out_col_r != COL_ZERO);
    rt_ok_s     = (out_col_r != COL_LAST);
    nb_strong_s = (up_ok_s & ((lf_ok_s & is_strong(top_l_r)) | is_strong(top_c_r)
                              | (rt_ok_s & is_strong(lb_hi_out_s))))
                | (lf_ok_s & is_strong(lb_hi_tap1_s))
                | (rt_ok_s & is_strong(lb_lo_out_s))
                | (dn_ok_s & ((lf_ok_s & is_strong(lb_lo_tap1_s)) | is_strong(lb_lo_tap0_s)
                              | (rt_ok_s & is_strong(din_s))));
    edge_s      = is_strong(lb_hi_tap0_s) | (is_weak(lb_hi_tap0_s) & nb_strong_s);
  end

  // Registered outputs and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_r       <= 1'b0;
      edge_valid_r <= 1'b0;
      frame_done_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      edge_r       <= emit_s & edge_s;
      edge_valid_r <= emit_s;
      frame_done_r <= emit_s & out_last_s;
      frame_err_r  <= frame_err_r | err_set_s;
    end
  end

  assign edge_flag  = edge_r;
  assign edge_valid = edge_valid_r;
  assign frame_done = frame_done_r;
  assign frame_err  = frame_err_r;

endmodule
